// File: rtl/ifetch.sv
// ifetch: instruction fetch stage feeding the decoder.
// Holds the PC and requests halfword-aligned words from the icache.
// Sizes each instruction (RV32C or 32-bit) and predicts JAL/backward branches as taken.
// After a JALR it parks in HALT until a ROB flush supplies the real target.
module ifetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          AGE_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 stall_in,
    input  logic                 need_flush_in,
    input  logic [31:0]          flush_pc,
    output logic                 ic_req,
    output logic [31:0]          ic_addr,
    input  logic                 ic_resp_valid,
    input  logic [31:0]          ic_resp_addr,
    input  logic [31:0]          ic_resp_data,
    output logic                 if_valid,
    output logic [31:0]          if_instr,
    output logic [31:0]          if_instr_addr,
    output logic [AGE_WIDTH-1:0] if_age,
    output logic                 if_is_jump,
    output logic [31:0]          if_jump_addr
);

    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [31:0]            pc_r;
    logic [31:0]            pc_next_s;
    logic [AGE_WIDTH-1:0]   age_r;

    logic                   accept_s;
    logic                   is_rvc_s;
    logic [31:0]            seq_pc_s;
    logic [31:0]            j_imm_s;
    logic [31:0]            b_imm_s;
    logic                   taken_s;
    logic                   is_jalr_s;
    logic [31:0]            target_s;

    // Decode the response word: accept test, length, immediates and static prediction.
    always_comb begin
        accept_s  = (state_r == ST_FETCH) && ic_resp_valid && (ic_resp_addr == pc_r)
                    && !stall_in && !need_flush_in;
        is_rvc_s  = (ic_resp_data[1:0] != 2'b11);
        seq_pc_s  = pc_r + (is_rvc_s ? 32'd2 : 32'd4);
        j_imm_s   = {{11{ic_resp_data[31]}}, ic_resp_data[31], ic_resp_data[19:12],
                     ic_resp_data[20], ic_resp_data[30:21], 1'b0};
        b_imm_s   = {{19{ic_resp_data[31]}}, ic_resp_data[31], ic_resp_data[7],
                     ic_resp_data[30:25], ic_resp_data[11:8], 1'b0};
        taken_s   = 1'b0;
        is_jalr_s = 1'b0;
        target_s  = seq_pc_s;
        if (!is_rvc_s) begin
            case (ic_resp_data[6:0])
                OP_JAL: begin
                    taken_s  = 1'b1;
                    target_s = pc_r + j_imm_s;
                end
                OP_BRANCH: begin
                    // Backward branches (negative offset) are predicted taken.
                    taken_s  = ic_resp_data[31];
                    target_s = ic_resp_data[31] ? (pc_r + b_imm_s) : seq_pc_s;
                end
                OP_JALR: begin
                    is_jalr_s = 1'b1;
                    taken_s   = 1'b0;
                    target_s  = seq_pc_s;
                end
                default: begin
                    taken_s  = 1'b0;
                    target_s = seq_pc_s;
                end
            endcase
        end else begin
            taken_s  = 1'b0;
            target_s = seq_pc_s;
        end
    end

    // Next state and next PC: flush wins, JALR parks in HALT with the PC unchanged.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        if (need_flush_in) begin
            state_next_s = ST_FETCH;
            pc_next_s    = flush_pc;
        end else if (accept_s) begin
            if (is_jalr_s) begin
                state_next_s = ST_HALT;
                pc_next_s    = pc_r;
            end else begin
                state_next_s = ST_FETCH;
                pc_next_s    = target_s;
            end
        end else begin
            state_next_s = state_r;
            pc_next_s    = pc_r;
        end
    end

    // FSM state register, frozen while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= ST_FETCH;
        end else if (rdy_in) begin
            state_r <= state_next_s;
        end
    end

    // PC, age and registered icache / decoder-facing outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            pc_r          <= RESET_PC;
            age_r         <= '0;
            ic_req        <= 1'b0;
            ic_addr       <= 32'h0;
            if_valid      <= 1'b0;
            if_instr      <= 32'h0;
            if_instr_addr <= 32'h0;
            if_age        <= '0;
            if_is_jump    <= 1'b0;
            if_jump_addr  <= 32'h0;
        end else if (!rdy_in) begin
            if_valid <= 1'b0;
        end else begin
            pc_r     <= pc_next_s;
            ic_req   <= (state_next_s == ST_FETCH);
            ic_addr  <= pc_next_s;
            if_valid <= accept_s;
            if (accept_s) begin
                if_instr      <= ic_resp_data;
                if_instr_addr <= pc_r;
                if_age        <= age_r;
                if_is_jump    <= taken_s;
                if_jump_addr  <= target_s;
                age_r         <= age_r + AGE_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scenarios plus a randomized run against a transaction-level model.
module tb_ifetch;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        stall_in;
    logic        need_flush_in;
    logic [31:0] flush_pc;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_resp_valid;
    logic [31:0] ic_resp_addr;
    logic [31:0] ic_resp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_instr_addr;
    logic [31:0] if_age;
    logic        if_is_jump;
    logic [31:0] if_jump_addr;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_age;

    // Random program: word, kind (0 plain32, 1 rvc, 2 jal, 3 branch, 4 jalr) and offset per address.
    logic [31:0] mem_word [logic [31:0]];
    int          mem_kind [logic [31:0]];
    int          mem_off  [logic [31:0]];

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifetch #(.RESET_PC(32'h0), .AGE_WIDTH(32)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .stall_in(stall_in),
        .need_flush_in(need_flush_in), .flush_pc(flush_pc),
        .ic_req(ic_req), .ic_addr(ic_addr),
        .ic_resp_valid(ic_resp_valid), .ic_resp_addr(ic_resp_addr), .ic_resp_data(ic_resp_data),
        .if_valid(if_valid), .if_instr(if_instr), .if_instr_addr(if_instr_addr),
        .if_age(if_age), .if_is_jump(if_is_jump), .if_jump_addr(if_jump_addr)
    );

    always #5 clk_in = ~clk_in;

    // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic st, input logic fl, input logic [31:0] fp, input logic rd);
        ic_resp_valid = v;
        ic_resp_addr  = a;
        ic_resp_data  = d;
        stall_in      = st;
        need_flush_in = fl;
        flush_pc      = fp;
        rdy_in        = rd;
        @(posedge clk_in);
        #1;
    endtask

    task automatic get_mem(input logic [31:0] a, output logic [31:0] w);
        int          k;
        int          off;
        int          kind;
        logic [31:0] x;
        logic [20:0] ji;
        logic [12:0] bi;
        if (!mem_word.exists(a)) begin
            k    = int'($urandom_range(0, 15));
            x    = $urandom;
            off  = 0;
            if (k < 5) begin
                kind   = 1;
                x[1:0] = 2'($urandom_range(0, 2));
            end else if (k < 9) begin
                kind   = 0;
                x[6:0] = 7'b0010011;
            end else if (k < 11) begin
                kind = 2;
                off  = (int'($urandom_range(0, 64)) - 32) * 2;
                ji   = 21'(off);
                x    = {ji[20], ji[10:1], ji[11], ji[19:12], x[11:7], 7'b1101111};
            end else if (k < 15) begin
                kind = 3;
                off  = (int'($urandom_range(0, 64)) - 32) * 2;
                bi   = 13'(off);
                x    = {bi[12], bi[10:5], x[24:20], x[19:15], x[14:12], bi[4:1], bi[11], 7'b1100011};
            end else begin
                kind   = 4;
                x[6:0] = 7'b1100111;
            end
            mem_word[a] = x;
            mem_kind[a] = kind;
            mem_off[a]  = off;
        end
        w = mem_word[a];
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({ic_req, ic_addr, if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%b addr=%h v=%b instr=%h ia=%h age=%h j=%b ja=%h want all zero",
                     ic_req, ic_addr, if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr);
        end
        rst_in  = 1'b1;
        exp_age = 32'h0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(4 * i), NOP, 1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr} !==
                {1'b1, 32'(4 * i), exp_age, 1'b0, 32'(4 * i + 4)}) begin
                n_fail++;
                $display("FAIL seq_issue[%0d]: got v=%b ia=%h age=%0d j=%b ja=%h want ia=%h age=%0d ja=%h",
                         i, if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, 4 * i, exp_age, 4 * i + 4);
            end
            exp_age++;
        end
        n_cmp++;
        if ({ic_req, ic_addr} !== {1'b1, 32'hC}) begin
            n_fail++;
            $display("FAIL seq_ic_addr: got req=%b addr=%h want req=1 addr=0000000c", ic_req, ic_addr);
        end
    endtask

    task automatic test_jal();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1);
        drive(1'b1, 32'h100, 32'h0100_006F, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr} !==
            {1'b1, 32'h100, exp_age, 1'b1, 32'h110, 32'h110}) begin
            n_fail++;
            $display("FAIL jal: got v=%b ia=%h age=%0d j=%b ja=%h ic_addr=%h want 1/100/%0d/1/110/110",
                     if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr, exp_age);
        end
        exp_age++;
    endtask

    task automatic test_branch();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1);
        drive(1'b1, 32'h200, 32'hFE00_0CE3, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr} !==
            {1'b1, 32'h200, exp_age, 1'b1, 32'h1F8, 32'h1F8}) begin
            n_fail++;
            $display("FAIL beq_back: got v=%b ia=%h age=%0d j=%b ja=%h ic_addr=%h want 1/200/%0d/1/1f8/1f8",
                     if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr, exp_age);
        end
        exp_age++;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h200, 1'b1);
        drive(1'b1, 32'h200, 32'h0000_0463, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr} !==
            {1'b1, 32'h200, exp_age, 1'b0, 32'h204, 32'h204}) begin
            n_fail++;
            $display("FAIL beq_fwd: got v=%b ia=%h age=%0d j=%b ja=%h ic_addr=%h want 1/200/%0d/0/204/204",
                     if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_addr, exp_age);
        end
        exp_age++;
    endtask

    task automatic test_compressed();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b1);
        drive(1'b1, 32'h300, 32'h0000_0505, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr} !==
            {1'b1, 32'h505, 32'h300, exp_age, 1'b0, 32'h302}) begin
            n_fail++;
            $display("FAIL rvc: got v=%b i=%h ia=%h age=%0d j=%b ja=%h want 1/505/300/%0d/0/302",
                     if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr, exp_age);
        end
        exp_age++;
        drive(1'b1, 32'h302, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr} !==
            {1'b1, 32'h302, exp_age, 1'b0, 32'h306}) begin
            n_fail++;
            $display("FAIL after_rvc: got v=%b ia=%h age=%0d j=%b ja=%h want 1/302/%0d/0/306",
                     if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, exp_age);
        end
        exp_age++;
    endtask

    task automatic test_jalr_halt();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400, 1'b1);
        drive(1'b1, 32'h400, 32'h0000_80E7, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_req} !==
            {1'b1, 32'h400, exp_age, 1'b0, 32'h404, 1'b0}) begin
            n_fail++;
            $display("FAIL jalr: got v=%b ia=%h age=%0d j=%b ja=%h req=%b want 1/400/%0d/0/404/0",
                     if_valid, if_instr_addr, if_age, if_is_jump, if_jump_addr, ic_req, exp_age);
        end
        exp_age++;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, (i % 2 == 0) ? 32'h400 : 32'h404, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({if_valid, ic_req} !== 2'b00) begin
                n_fail++;
                $display("FAIL halt_quiet[%0d]: got v=%b req=%b want 0/0", i, if_valid, ic_req);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500, 1'b1);
        n_cmp++;
        if ({if_valid, ic_req, ic_addr} !== {1'b0, 1'b1, 32'h500}) begin
            n_fail++;
            $display("FAIL halt_flush: got v=%b req=%b addr=%h want 0/1/500", if_valid, ic_req, ic_addr);
        end
        drive(1'b1, 32'h500, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age} !== {1'b1, 32'h500, exp_age}) begin
            n_fail++;
            $display("FAIL resume: got v=%b ia=%h age=%0d want 1/500/%0d", if_valid, if_instr_addr, if_age, exp_age);
        end
        exp_age++;
    endtask

    task automatic test_blocked();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h600, NOP, 1'b1, 1'b0, 32'h0, 1'b1);
            n_cmp++;
            if ({if_valid, ic_addr, if_instr_addr} !== {1'b0, 32'h600, 32'h500}) begin
                n_fail++;
                $display("FAIL stall[%0d]: got v=%b addr=%h ia=%h want 0/600/500", i, if_valid, ic_addr, if_instr_addr);
            end
        end
        drive(1'b1, 32'h600, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age, if_jump_addr} !== {1'b1, 32'h600, exp_age, 32'h604}) begin
            n_fail++;
            $display("FAIL unstall: got v=%b ia=%h age=%0d ja=%h want 1/600/%0d/604",
                     if_valid, if_instr_addr, if_age, if_jump_addr, exp_age);
        end
        exp_age++;
        drive(1'b1, 32'h604, NOP, 1'b0, 1'b1, 32'h700, 1'b1);
        n_cmp++;
        if ({if_valid, ic_addr, if_instr_addr} !== {1'b0, 32'h700, 32'h600}) begin
            n_fail++;
            $display("FAIL flush_drop: got v=%b addr=%h ia=%h want 0/700/600", if_valid, ic_addr, if_instr_addr);
        end
        drive(1'b1, 32'h700, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 32'h800, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, ic_addr} !== {1'b0, 32'h704}) begin
            n_fail++;
            $display("FAIL wrong_addr: got v=%b addr=%h want 0/704", if_valid, ic_addr);
        end
        drive(1'b1, 32'h704, NOP, 1'b0, 1'b0, 32'h0, 1'b0);
        n_cmp++;
        if ({if_valid, ic_addr} !== {1'b0, 32'h704}) begin
            n_fail++;
            $display("FAIL not_ready: got v=%b addr=%h want 0/704", if_valid, ic_addr);
        end
        exp_age++;
        drive(1'b1, 32'h704, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        n_cmp++;
        if ({if_valid, if_instr_addr, if_age} !== {1'b1, 32'h704, exp_age}) begin
            n_fail++;
            $display("FAIL ready_again: got v=%b ia=%h age=%0d want 1/704/%0d", if_valid, if_instr_addr, if_age, exp_age);
        end
        exp_age++;
    endtask

    task automatic test_random();
        logic [31:0]  m_pc;
        logic         m_halt;
        int           halt_cnt;
        logic         rd, st, fl, v, exp_acc, taken;
        logic [31:0]  fp, a, d, exp_ja;
        logic [127:0] prev_obs;
        int           kind, len;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1000, 1'b1);
        m_pc     = 32'h1000;
        m_halt   = 1'b0;
        halt_cnt = 0;
        prev_obs = {if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr[30:0]};
        for (int c = 0; c < 800; c++) begin
            rd = ($urandom_range(0, 9) != 0);
            st = ($urandom_range(0, 4) == 0);
            fl = rd && (m_halt ? (halt_cnt >= 3) : ($urandom_range(0, 29) == 0));
            fp = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd2;
            v  = ($urandom_range(0, 3) != 0);
            a  = ic_addr;
            if ($urandom_range(0, 7) == 0) a = ic_addr + 32'd2;
            get_mem(a, d);
            exp_acc = rd && !st && !fl && !m_halt && v && (a == m_pc);
            drive(v, a, d, st, fl, fp, rd);
            n_cmp++;
            if (if_valid !== exp_acc) begin
                n_fail++;
                $display("FAIL rnd_valid[%0d]: got %b want %b (pc=%h)", c, if_valid, exp_acc, m_pc);
            end
            if (exp_acc) begin
                kind   = mem_kind[m_pc];
                len    = (kind == 1) ? 2 : 4;
                taken  = (kind == 2) || (kind == 3 && mem_off[m_pc] < 0);
                exp_ja = taken ? m_pc + 32'(mem_off[m_pc]) : m_pc + 32'(len);
                n_cmp++;
                if ({if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr} !==
                    {mem_word[m_pc], m_pc, exp_age, taken, exp_ja}) begin
                    n_fail++;
                    $display("FAIL rnd_issue[%0d]: got i=%h ia=%h age=%0d j=%b ja=%h want i=%h ia=%h age=%0d j=%b ja=%h",
                             c, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr,
                             mem_word[m_pc], m_pc, exp_age, taken, exp_ja);
                end
                exp_age++;
                if (kind == 4) m_halt = 1'b1;
                else m_pc = exp_ja;
            end else begin
                n_cmp++;
                if ({if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr[30:0]} !== prev_obs) begin
                    n_fail++;
                    $display("FAIL rnd_hold[%0d]: outputs changed without a valid issue", c);
                end
            end
            prev_obs = {if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr[30:0]};
            if (fl) begin
                m_pc     = fp;
                m_halt   = 1'b0;
                halt_cnt = 0;
            end
            if (m_halt) halt_cnt++;
            n_cmp++;
            if (m_halt ? (ic_req !== 1'b0) : ({ic_req, ic_addr} !== {1'b1, m_pc})) begin
                n_fail++;
                $display("FAIL rnd_req[%0d]: got req=%b addr=%h want req=%b addr=%h", c, ic_req, ic_addr, !m_halt, m_pc);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2000, 1'b1);
        drive(1'b1, 32'h2000, NOP, 1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        rst_in = 1'b0;
        #1;
        n_cmp++;
        if ({ic_req, ic_addr, if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got req=%b addr=%h v=%b instr=%h ia=%h age=%h j=%b ja=%h want all zero",
                     ic_req, ic_addr, if_valid, if_instr, if_instr_addr, if_age, if_is_jump, if_jump_addr);
        end
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
    endtask

    initial begin
        rst_in        = 1'b0;
        rdy_in        = 1'b1;
        stall_in      = 1'b0;
        need_flush_in = 1'b0;
        flush_pc      = 32'h0;
        ic_resp_valid = 1'b0;
        ic_resp_addr  = 32'h0;
        ic_resp_data  = 32'h0;
        exp_age       = 32'h0;
        #2;
        test_reset();
        test_sequential();
        test_jal();
        test_branch();
        test_compressed();
        test_jalr_halt();
        test_blocked();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
